// File: rtl/dot_result_bcd_conv_if.sv
// ---------------------------------------------------------------------------
// dot_result_bcd_conv_if
// Connects the dot-product MAC result to the binary-to-BCD converter.
// The master side (accumulator/sequencer) raises a conversion request.
// The slave side (the converter) returns the decimal digits and status.
//
//   start    : master -> slave, conversion request, level-sampled each clock
//   bin      : master -> slave, IN_W-bit unsigned value to convert
//   oflo_in  : master -> slave, MAC overflow flag, captured together with bin
//   busy     : slave -> master, high while a conversion is in flight
//   done     : slave -> master, one-cycle pulse when the results update
//   bcd      : slave -> master, DIGITS packed BCD digits, digit 0 in bits [3:0]
//   blank    : slave -> master, leading-zero mask, bit i covers digit i
//   oflo_out : slave -> master, overflow flag belonging to the current bcd
// ---------------------------------------------------------------------------
interface dot_result_bcd_conv_if #(
   parameter int IN_W   = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [IN_W-1:0]       bin;
   logic                  oflo_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     blank;
   logic                  oflo_out;

   modport master (
      output start, bin, oflo_in,
      input  busy, done, bcd, blank, oflo_out
   );

   modport slave (
      input  start, bin, oflo_in,
      output busy, done, bcd, blank, oflo_out
   );
endinterface

// File: rtl/dot_result_bcd_conv.sv
// ---------------------------------------------------------------------------
// dot_result_bcd_conv
// Sequential double-dabble binary-to-BCD converter. It sits between the MAC
// accumulator and the seven-segment controller, so the dot product can be
// shown in decimal. One input bit is consumed per clock. The results appear
// IN_W clocks after the accepting edge, and they are flagged by a one-cycle
// done pulse.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of dot_result_bcd_conv_if
//           inputs:  start, bin, oflo_in
//           outputs: busy, done, bcd, blank, oflo_out
// ---------------------------------------------------------------------------
module dot_result_bcd_conv #(
   parameter int IN_W   = 16,
   parameter int DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   dot_result_bcd_conv_if.slave    bus
);

   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BCD_W = 4 * DIGITS;
   // Every digit except digit 0 is blanked while the displayed value is zero.
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [IN_W-1:0]     shift_q;
   logic [BCD_W-1:0]    work_q;
   logic                oflo_hold;

   logic                busy_q;
   logic                done_q;
   logic [BCD_W-1:0]    bcd_q;
   logic [DIGITS-1:0]   blank_q;
   logic                oflo_out_q;

   logic [BCD_W-1:0]    work_adj;
   logic [BCD_W-1:0]    work_nxt;
   logic [IN_W-1:0]     shift_nxt;
   logic [DIGITS-1:0]   blank_nxt;
   logic                zero_run;

   // This block computes one double-dabble iteration: first the per-digit +3
   // correction, then the one-bit shift. It also computes the blank mask for
   // the result of that iteration. The mask is only used at the last
   // iteration.
   always_comb begin
      // NOTE: every signal gets a default before any conditional assignment,
      // so no path leaves a value unassigned and no latch is inferred.
      work_adj  = work_q;
      blank_nxt = '0;
      zero_run  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5) begin
            // A 4-bit add. It never carries out, because a digit of at most
            // 9 plus 3 is at most 12.
            work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
         end
      end
      work_nxt  = {work_adj[BCD_W-2:0], shift_q[IN_W-1]};
      shift_nxt = {shift_q[IN_W-2:0], 1'b0};
      // Scan from the most significant digit downwards. Digit i is a leading
      // zero when it and every digit above it are zero. Digit 0 is never
      // blanked.
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_run     = zero_run && (work_nxt[4*i +: 4] == 4'd0);
         blank_nxt[i] = zero_run;
      end
   end

   // NOTE: all state is updated with non-blocking assignments. Every register
   // therefore samples values from before the edge, whatever the statement
   // order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shift_q    <= '0;
         work_q     <= '0;
         oflo_hold  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         blank_q    <= BLANK_RST;
         oflo_out_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shift_q   <= bus.bin;
                  oflo_hold <= bus.oflo_in;
                  work_q    <= '0;
                  cnt       <= '0;
                  busy_q    <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               work_q  <= work_nxt;
               shift_q <= shift_nxt;
               cnt     <= cnt + 1'b1;
               if (cnt == CNT_W'(IN_W - 1)) begin
                  // Last iteration. The visible outputs change only here,
                  // so they never show a partial result.
                  bcd_q      <= work_nxt;
                  blank_q    <= blank_nxt;
                  oflo_out_q <= oflo_hold;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.blank    = blank_q;
   assign bus.oflo_out = oflo_out_q;

endmodule
